// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage RAW hazard detection, stall/flush sequencing and flush recovery pulse.
// Optional feature macro HAZARD_FWD_EN: forwarding selects, only stage-0 load-use hazards stall.
module hazard_ctrl #(
    parameter int unsigned REG_AW       = 4,
    parameter int unsigned NUM_INFLIGHT = 2,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [REG_AW-1:0]                    rs1D,
    input  logic [REG_AW-1:0]                    rs2D,
    input  logic                                 rs1_useD,
    input  logic                                 rs2_useD,
    input  logic [NUM_INFLIGHT*REG_AW-1:0]       rd_vec,
    input  logic [NUM_INFLIGHT-1:0]              rd_wen_vec,
    input  logic                                 branch_takenE,
`ifdef HAZARD_FWD_EN
    input  logic [NUM_INFLIGHT-1:0]              ld_vec,
    output logic [$clog2(NUM_INFLIGHT+1)-1:0]    fwd_rs1_sel,
    output logic [$clog2(NUM_INFLIGHT+1)-1:0]    fwd_rs2_sel,
`endif
    output logic                                 stall,
    output logic                                 flush,
    output logic                                 flush_done,
    output logic                                 busy
);

    localparam int unsigned MaxCnt = (NUM_INFLIGHT > FLUSH_CYCLES) ? NUM_INFLIGHT : FLUSH_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);
    localparam logic [CntW-1:0] FlushInit = CntW'(FLUSH_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);

    typedef enum logic [1:0] {StIdle, StStall, StFlush} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            flush_done_q, flush_done_d;

    logic [NUM_INFLIGHT-1:0] hit1, hit2;
    logic [CntW-1:0]         stall_len;
    logic                    need_stall;

    for (genvar i = 0; i < NUM_INFLIGHT; i++) begin : g_cmp
        logic [REG_AW-1:0] rd;
        logic              live;
        assign rd      = rd_vec[i*REG_AW +: REG_AW];
        assign live    = rd_wen_vec[i] && (rd != '0);
        assign hit1[i] = live && rs1_useD && (rs1D == rd);
        assign hit2[i] = live && rs2_useD && (rs2D == rd);
    end

`ifdef HAZARD_FWD_EN
    localparam int unsigned SelW = $clog2(NUM_INFLIGHT + 1);
    logic [SelW-1:0] sel1, sel2;

    // Descending scan so the youngest matching stage wins.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        for (int i = NUM_INFLIGHT - 1; i >= 0; i--) begin
            if (hit1[i]) sel1 = SelW'(i + 1);
            if (hit2[i]) sel2 = SelW'(i + 1);
        end
    end

    // Only a load in EX cannot be forwarded in time.
    assign need_stall  = (hit1[0] || hit2[0]) && ld_vec[0];
    assign stall_len   = CntOne;
    assign fwd_rs1_sel = flush ? '0 : sel1;
    assign fwd_rs2_sel = flush ? '0 : sel2;
`else
    logic [NUM_INFLIGHT-1:0] hit;
    assign hit = hit1 | hit2;

    always_comb begin
        stall_len = '0;
        for (int i = NUM_INFLIGHT - 1; i >= 0; i--) begin
            if (hit[i]) stall_len = CntW'(NUM_INFLIGHT - i);
        end
    end

    assign need_stall = |hit;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_done_d = 1'b0;
        stall        = 1'b0;
        flush        = 1'b0;
        // Outputs are gated during reset so an asserted reset reads all-zero immediately.
        if (!reset) begin
            unique case (state_q)
                StIdle: begin
                    if (branch_takenE) begin
                        flush = 1'b1;
                        if (FlushInit == '0) begin
                            flush_done_d = 1'b1;
                        end else begin
                            state_d = StFlush;
                            cnt_d   = FlushInit;
                        end
                    end else if (need_stall) begin
                        stall = 1'b1;
                        if (stall_len > CntOne) begin
                            state_d = StStall;
                            cnt_d   = stall_len - CntOne;
                        end
                    end
                end
                StStall: begin
                    if (branch_takenE) begin
                        flush = 1'b1;
                        if (FlushInit == '0) begin
                            state_d      = StIdle;
                            cnt_d        = '0;
                            flush_done_d = 1'b1;
                        end else begin
                            state_d = StFlush;
                            cnt_d   = FlushInit;
                        end
                    end else begin
                        stall = 1'b1;
                        if (cnt_q == CntOne) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q - CntOne;
                        end
                    end
                end
                StFlush: begin
                    flush = 1'b1;
                    if (cnt_q == CntOne) begin
                        state_d      = StIdle;
                        cnt_d        = '0;
                        flush_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign flush_done = flush_done_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised hazard and control-flow unit for the multi-stage pipelines.
- Compares decode-stage source registers against NUM_INFLIGHT downstream destination registers.
- Stalls decode for a distance-dependent number of cycles and flushes for FLUSH_CYCLES cycles on a taken branch.
- Emits a one-cycle recovery pulse when a flush completes.
- Sits beside the decode stage; drives the IF/ID enables and the ID/EX bubble insert.

Parameters:
REG_AW, 4, register address width; register 0 is hardwired zero and never a hazard.
NUM_INFLIGHT, 2, number of in-flight stages checked; index 0 = EX (youngest), range 1..4.
FLUSH_CYCLES, 2, total cycles flush stays high per taken branch, range 1..8.

Ports:
clk  in  1  pipeline clock, rising edge.
reset  in  1  asynchronous, active-high reset.
rs1D  in  REG_AW  decode source register 1.
rs2D  in  REG_AW  decode source register 2.
rs1_useD  in  1  decode instruction reads rs1.
rs2_useD  in  1  decode instruction reads rs2.
rd_vec  in  NUM_INFLIGHT*REG_AW  destination registers; slice i = stage i.
rd_wen_vec  in  NUM_INFLIGHT  stage i writes its rd.
branch_takenE  in  1  taken branch resolved in EX this cycle.
stall  out  1  hold PC and IF/ID, insert bubble into ID/EX.
flush  out  1  squash IF/ID and ID/EX contents.
flush_done  out  1  one-cycle pulse, cycle after last flush cycle.
busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: single clock; reset is asynchronous and active-high. On reset: state=IDLE, cnt=0, flush_done=0; stall, flush and busy read 0.
- Hazard match for stage i: rd_wen_vec[i] && rd_vec[i]!=0 && ((rs1_useD && rs1D==rd[i]) || (rs2_useD && rs2D==rd[i])).
- k is the smallest matching i (youngest producer). Required stall length L = NUM_INFLIGHT - k.
- Counter width: clog2(max(NUM_INFLIGHT, FLUSH_CYCLES)+1).
- States: IDLE, STALL, FLUSH.
- IDLE:
  - branch_takenE: flush=1 combinationally, stall=0. Go to FLUSH with cnt=FLUSH_CYCLES-1; if that is 0, stay IDLE and pulse flush_done next cycle.
  - Else if any match: stall=1 combinationally. Go to STALL with cnt=L-1; if L=1, stay IDLE.
  - Else all outputs 0.
- STALL:
  - stall=1.
  - branch_takenE has priority: stall=0, flush=1, go to FLUSH with cnt=FLUSH_CYCLES-1.
  - Else if cnt==1 go to IDLE, else cnt--.
  - Matches are not re-evaluated during STALL.
- FLUSH:
  - flush=1, stall=0.
  - branch_takenE is ignored.
  - If cnt==1, go to IDLE and set flush_done=1 for exactly the next cycle. Else cnt--.
- flush_done is registered and never overlaps flush.
- Stall and flush are never both 1. Flush wins any simultaneous event.
- Reset mid-STALL or mid-FLUSH aborts immediately: outputs 0, no flush_done pulse.

Optional Feature:
HAZARD_FWD_EN
- Defined: adds input ld_vec [NUM_INFLIGHT] (stage i is a load) and outputs fwd_rs1_sel / fwd_rs2_sel [clog2(NUM_INFLIGHT+1)].
  - Select value = k+1 of the youngest stage matching that source; 0 = register file.
  - Only a stage-0 match with ld_vec[0]=1 stalls, for exactly 1 cycle. All other matches forward with no stall.
  - Selects are combinational and forced to 0 while flush=1.
- Undefined: these ports are absent and every match stalls for L cycles as above.

Test Plan:
1. NUM_INFLIGHT=2: rs1D=3, rs1_useD=1, rd_vec[0]=3, wen[0]=1 -> stall high exactly 2 cycles, busy high during 2nd, then 0.
2. rs2D=5 matches only rd_vec[1]=5 -> stall high 1 cycle, state stays IDLE; rd=0 with wen=1 -> no stall.
3. branch_takenE pulse in IDLE, FLUSH_CYCLES=2 -> flush high 2 cycles, flush_done high on 3rd cycle only, stall 0 throughout.
4. Branch in 2nd cycle of a 2-cycle stall -> stall drops that cycle, flush high 2 cycles, flush_done pulse. Second branch during FLUSH -> no extension.
5. Reset asserted asynchronously mid-FLUSH -> outputs 0 before next edge, no flush_done. Normal detection resumes after release.
6. HAZARD_FWD_EN, rs1 matches stage 1, rs2 matches non-load stage 0 -> fwd_rs1_sel=2, fwd_rs2_sel=1, no stall. Stage-0 load match -> 1-cycle stall.
